palette_loader: RTL and testbench

//  Write-side master for the colour palette: accepts a byte stream (valid/ready/last) from the

---
 rtl/palette_loader.sv | 151 +++++++++++++++
 tb/tb_palette_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
// rtl/palette_loader.sv - byte-stream parser driving the colour palette write port
module palette_loader #(
   parameter  int PALETTE_LENGTH = 256,
   parameter  int COLOR_BITS     = 12,
   localparam int INDEX_BITS     = $clog2(PALETTE_LENGTH)
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [7:0]            s_data_i,
   input  logic                  s_valid_i,
   input  logic                  s_last_i,
   output logic                  s_ready_o,
   output logic                  wr_en_o,
   output logic [INDEX_BITS-1:0] wr_index_o,
   output logic [COLOR_BITS-1:0] wr_color_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CNT   = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic [8:0]            rem_q, rem_d;
   // only the hi bits that survive into the colour word are kept
   logic [COLOR_BITS-9:0] hi_q, hi_d;
   logic                  wr_en_q, wr_en_d;
   logic [INDEX_BITS-1:0] wr_index_q, wr_index_d;
   logic [COLOR_BITS-1:0] wr_color_q, wr_color_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  accept;

   assign accept = s_valid_i & ready_q;

   // next-state and registered-output computation; only accepted bytes advance the parser
   always_comb begin
      state_d    = state_q;
      ready_d    = 1'b1;
      idx_d      = idx_q;
      rem_d      = rem_q;
      hi_d       = hi_q;
      wr_en_d    = 1'b0;
      wr_index_d = wr_index_q;
      wr_color_d = wr_color_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               idx_d = s_data_i[INDEX_BITS-1:0];
               if (s_last_i) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_CNT;
               end
            end
            ST_CNT: begin
               rem_d = {1'b0, s_data_i} + 9'd1;
               if (s_last_i) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HI;
               end
            end
            ST_HI: begin
               hi_d = s_data_i[COLOR_BITS-9:0];
               if (s_last_i) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_LO;
               end
            end
            ST_LO: begin
               // the write always goes out, even when this byte ends the packet early
               wr_en_d    = 1'b1;
               wr_index_d = idx_q;
               wr_color_d = {hi_q, s_data_i};
               idx_d      = idx_q + 1'b1;
               rem_d      = rem_q - 9'd1;
               if (rem_q == 9'd1) begin
                  if (s_last_i) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else if (s_last_i) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HI;
               end
            end
            ST_DRAIN: begin
               if (s_last_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // state and output registers; reset drops any write that was about to be issued
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         idx_q      <= '0;
         rem_q      <= '0;
         hi_q       <= '0;
         wr_en_q    <= 1'b0;
         wr_index_q <= '0;
         wr_color_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         hi_q       <= hi_d;
         wr_en_q    <= wr_en_d;
         wr_index_q <= wr_index_d;
         wr_color_q <= wr_color_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign s_ready_o  = ready_q;
   assign wr_en_o    = wr_en_q;
   assign wr_index_o = wr_index_q;
   assign wr_color_o = wr_color_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_palette_loader.sv
// tb/tb_palette_loader.sv - scoreboard bench for palette_loader (12-bit and 16-bit colour)
module tb_palette_loader;

   logic       clk = 1'b0;
   logic       reset_ni = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;

   logic        rdy_a, wr_a, busy_a, done_a, err_a;
   logic [7:0]  idx_a;
   logic [11:0] col_a;
   logic        rdy_b, wr_b, busy_b, done_b, err_b;
   logic [7:0]  idx_b;
   logic [15:0] col_b;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit is_err;
      int idx;
      int hi;
      int lo;
      bit done;
   } ev_t;

   ev_t q12[$];
   ev_t q16[$];
   int  ph[256];
   int  pl[256];

   always #5 clk = ~clk;

   palette_loader #(.PALETTE_LENGTH(256), .COLOR_BITS(12)) dut_a (
      .clk_i(clk), .reset_ni(reset_ni), .s_data_i(s_data), .s_valid_i(s_valid),
      .s_last_i(s_last), .s_ready_o(rdy_a), .wr_en_o(wr_a), .wr_index_o(idx_a),
      .wr_color_o(col_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
   );

   palette_loader #(.PALETTE_LENGTH(256), .COLOR_BITS(16)) dut_b (
      .clk_i(clk), .reset_ni(reset_ni), .s_data_i(s_data), .s_valid_i(s_valid),
      .s_last_i(s_last), .s_ready_o(rdy_b), .wr_en_o(wr_b), .wr_index_o(idx_b),
      .wr_color_o(col_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_write(input int idx, input int hi, input int lo, input bit done);
      ev_t e;
      e.is_err = 1'b0; e.idx = idx % 256; e.hi = hi; e.lo = lo; e.done = done;
      q12.push_back(e);
      q16.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1; e.idx = 0; e.hi = 0; e.lo = 0; e.done = 1'b0;
      q12.push_back(e);
      q16.push_back(e);
   endtask

   // one monitor step for either instance; colour is rebuilt from the raw hi/lo bytes
   task automatic mon_step(input bit w16, input logic wr, input logic [7:0] idx,
                           input logic [15:0] col, input logic done, input logic err);
      ev_t e;
      int  exp_col;
      string tag;
      tag = w16 ? "c16" : "c12";
      if (done && err) check({tag, "_done_err_excl"}, 1, 0);
      if (done && !wr) check({tag, "_done_without_write"}, 1, 0);
      if (wr) begin
         if ((w16 ? q16.size() : q12.size()) == 0) begin
            check({tag, "_unexpected_write"}, 1, 0);
         end else begin
            e = w16 ? q16.pop_front() : q12.pop_front();
            exp_col = w16 ? ((e.hi << 8) | e.lo) : (((e.hi & 15) << 8) | e.lo);
            check({tag, "_write_expected"}, {31'd0, e.is_err}, 0);
            check({tag, "_wr_index"}, {24'd0, idx}, e.idx);
            check({tag, "_wr_color"}, {16'd0, col}, exp_col);
            check({tag, "_done"}, {31'd0, done}, {31'd0, e.done});
         end
      end
      if (err) begin
         if ((w16 ? q16.size() : q12.size()) == 0) begin
            check({tag, "_unexpected_err"}, 1, 0);
         end else begin
            e = w16 ? q16.pop_front() : q12.pop_front();
            check({tag, "_err_expected"}, {31'd0, e.is_err}, 1);
         end
      end
   endtask

   // monitors sample on the falling edge, away from the active edge
   always @(negedge clk) mon_step(1'b0, wr_a, idx_a, {4'd0, col_a}, done_a, err_a);
   always @(negedge clk) mon_step(1'b1, wr_b, idx_b, col_b, done_b, err_b);

   task automatic wait_ready();
      int n;
      n = 0;
      while (!(rdy_a && rdy_b) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!(rdy_a && rdy_b)) check("ready_timeout", 0, 1);
   endtask

   task automatic send_byte(input int data, input bit last, input bit gaps);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         s_last  = 1'($urandom);
         repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      wait_ready();
      s_data  = 8'(data);
      s_last  = last;
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic rand_pairs();
      for (int i = 0; i < 256; i++) begin
         ph[i] = int'($urandom_range(0, 255));
         pl[i] = int'($urandom_range(0, 255));
      end
   endtask

   // mode 0: well framed; 1: last on byte position prm; 2: last missing, prm junk bytes follow
   task automatic run_packet(input int start, input int n, input int mode, input int prm,
                             input bit gaps);
      int bytes[$];
      int len, stop, k;
      bytes.push_back(start);
      bytes.push_back(n - 1);
      for (int i = 0; i < n; i++) begin
         bytes.push_back(ph[i]);
         bytes.push_back(pl[i]);
      end
      len = 2 + 2 * n;
      if (mode == 0) begin
         for (int i = 0; i < n; i++) push_write(start + i, ph[i], pl[i], i == n - 1);
         stop = len - 1;
      end else if (mode == 1) begin
         k = (prm >= 3) ? ((prm - 3) / 2 + 1) : 0;
         for (int i = 0; i < k; i++) push_write(start + i, ph[i], pl[i], 1'b0);
         push_err();
         stop = prm;
      end else begin
         for (int i = 0; i < n; i++) push_write(start + i, ph[i], pl[i], 1'b0);
         push_err();
         for (int j = 0; j < prm; j++) bytes.push_back(int'($urandom_range(0, 255)));
         stop = len + prm - 1;
      end
      for (int i = 0; i <= stop; i++) send_byte(bytes[i], i == stop, gaps);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("busy_idle_after_packet", {31'd0, busy_a | busy_b}, 0);
      #1;
   endtask

   initial begin
      int n, mode, prm;
      // reset state
      #2;
      check("rst_ready", {31'd0, rdy_a | rdy_b}, 0);
      check("rst_outputs", {31'd0, wr_a | wr_b | busy_a | busy_b | done_a | done_b | err_a | err_b}, 0);
      check("rst_index_color", {8'd0, idx_a, col_a} | {idx_b, col_b}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_ni = 1'b1;
      #1;
      check("ready_before_edge", {31'd0, rdy_a}, 0);
      @(posedge clk); #1;
      check("ready_after_release", {31'd0, rdy_a & rdy_b}, 1);

      // 05,01,0A,BC,0D,EF
      ph[0] = 8'h0A; pl[0] = 8'hBC; ph[1] = 8'h0D; pl[1] = 8'hEF;
      run_packet(8'h05, 2, 0, 0, 1'b0);
      // index wrap across the top
      rand_pairs();
      run_packet(8'hFE, 4, 0, 0, 1'b0);
      rand_pairs();
      run_packet(250, 10, 0, 0, 1'b1);
      // full 256-entry packet, with and without gaps
      rand_pairs();
      run_packet(int'($urandom_range(0, 255)), 256, 0, 0, 1'b0);
      rand_pairs();
      run_packet(int'($urandom_range(0, 255)), 256, 0, 0, 1'b1);
      // last on 2nd HI byte of a 3-entry packet, then a clean packet
      rand_pairs();
      run_packet(8'h40, 3, 1, 4, 1'b0);
      rand_pairs();
      run_packet(8'h41, 3, 0, 0, 1'b0);
      // 1-entry packet missing last, 3 junk bytes, then a clean packet
      rand_pairs();
      run_packet(8'h80, 1, 2, 3, 1'b0);
      rand_pairs();
      run_packet(8'h81, 2, 0, 0, 1'b0);

      // reset asserted while the LO byte is being offered
      send_byte(8'h10, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'hFF, 1'b0, 1'b0);
      s_data = 8'hAA; s_last = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      reset_ni = 1'b0;
      #1;
      check("midrst_outputs", {31'd0, wr_a | wr_b | busy_a | busy_b | done_a | done_b | err_a | err_b | rdy_a | rdy_b}, 0);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      check("midrst_no_write", {31'd0, wr_a | wr_b}, 0);
      check("midrst_index_color", {8'd0, idx_a, col_a} | {idx_b, col_b}, 0);
      @(negedge clk);
      reset_ni = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready_back", {31'd0, rdy_a & rdy_b}, 1);
      ph[0] = 8'hA5; pl[0] = 8'h3C; ph[1] = 8'hFF; pl[1] = 8'h01;
      run_packet(8'h22, 2, 0, 0, 1'b0);

      // randomized mix of framings
      for (int t = 0; t < 40; t++) begin
         rand_pairs();
         n    = int'($urandom_range(1, 8));
         mode = int'($urandom_range(0, 2));
         if (mode == 1) prm = int'($urandom_range(0, 2 * n));
         else if (mode == 2) prm = int'($urandom_range(1, 4));
         else prm = 0;
         run_packet(int'($urandom_range(0, 255)), n, mode, prm, 1'b1);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("q12_drained", q12.size(), 0);
      check("q16_drained", q16.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
